event_drain_arbiter: RTL and testbench
======================================

Name: event_drain_arbiter

Overview:
- Drains N event-monitor FIFOs into one registered valid/ready readout stream, tagging each event with its source index.
- Each source exposes a peek-style interface: `src_valid` with data visible, and a one-cycle `src_pop` to consume.
- Sources are scheduled round-robin with a bounded burst length.
- Sits between the per-probe monitor cores and the shared readout/bus bridge.

Parameters:
- N_SRC, 4, number of monitor sources (2..16).
- EVT_W, 72, event word width (timestamp+id+data).
- MAX_BURST, 4, max consecutive events taken from one source before rotating (1..16).
- CNT_W, 32, width of the forwarded-event counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enable; 0 blocks new pops, the output stage still drains.
- src_valid  in  N_SRC  per-source event available (FIFO not empty).
- src_data  in  N_SRC*EVT_W  per-source head-of-FIFO data; source i at bits [i*EVT_W +: EVT_W].
- src_pop  out  N_SRC  one-hot single-cycle pop to the granted source.
- out_valid  out  1  output event valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  EVT_W  event word.
- out_src  out  $clog2(N_SRC)  source index of out_data.
- busy  out  1  out_valid or any src_valid.
- evt_count  out  CNT_W  events forwarded (handshakes completed).
- cnt_clr  in  1  synchronous clear of evt_count.

Behaviour:

Reset (async, active-low):
- src_pop=0, out_valid=0, out_data=0, out_src=0, evt_count=0.
- rr_ptr=N_SRC-1, so source 0 has first priority.
- burst_cnt=0; FSM in IDLE.
- A reset mid-operation discards any event held in the output register. Its source was already popped, so the event is lost by design.

Output stage:
- One register. load_ok = !out_valid || out_ready.
- When a pop fires, out_data/out_src capture src_data[g]/g in the same cycle. Data is sampled before the pop takes effect.
- out_valid is set on load and cleared on a handshake with no new load.
- out_data/out_src are stable while out_valid && !out_ready.

Pop rule:
- A pop fires iff en && load_ok && a grant candidate exists.
- src_pop[g] is high for exactly that cycle.
- Latency: source valid to out_valid is 1 cycle.
- Throughput: 1 event/cycle when out_ready is held high.

FSM:
- IDLE: no lock.
  - Candidate = first i with src_valid[i] set, scanning from rr_ptr+1 cyclically.
  - On pop: lock to g, burst_cnt=1, go to BURST (or stay in IDLE if MAX_BURST==1, with rr_ptr=g).
- BURST (locked to s):
  - If src_valid[s] and burst_cnt<MAX_BURST, candidate = s; a pop increments burst_cnt.
  - Otherwise release: rr_ptr=s, burst_cnt=0, and in the same cycle arbitrate as in IDLE excluding nothing. There is no idle bubble.
  - When burst_cnt reaches MAX_BURST on a pop: rr_ptr=s, go to IDLE.
  - A stall (load_ok=0 or en=0) holds the lock and burst_cnt.
- The source deasserts src_valid the cycle after its last event is popped. The arbiter must never pop a source whose src_valid is low.

evt_count:
- +1 per out_valid && out_ready.
- Wraps modulo 2^CNT_W.
- cnt_clr wins over a simultaneous increment (result 0).

Simultaneous events:
- Handshake and new load in the same cycle: out_valid stays 1 with the new data.
- en falling during BURST: lock is kept and resumes when en returns.

Optional Feature:
- Macro: EVENT_DRAIN_ARB_URGENT_EN.
- With it defined:
  - Extra input port `src_urgent` [N_SRC] (e.g. tied to the source FIFO full flag).
  - Any src_urgent[i] && src_valid[i] preempts.
  - In IDLE, or at a release point, the urgent candidate is chosen round-robin among urgent sources first.
  - An active BURST on a non-urgent source ends after its current pop: rr_ptr is updated and the arbiter moves to IDLE.
- Without it: no port, pure round-robin as above.

Test Plan:
- Reset, then src_valid=4'b0101 with constant data, out_ready=1 → pops order src0 ×4, src2 ×4, src0 ×4…; out_src follows; evt_count=8 after 8 handshakes.
- Only src3 valid with 6 events (MAX_BURST=4), out_ready=1 → 6 back-to-back pops, out_valid continuous, no bubble at the burst boundary; src3 re-wins because it is the only candidate.
- out_ready=0 for 5 cycles while out_valid=1 → out_data/out_src constant, src_pop all 0; on release, one handshake per cycle resumes.
- en=0 with all sources valid → no src_pop; a pending out_valid still drains on out_ready; en=1 resumes from the held rr_ptr.
- Assert rst_n low mid-burst with out_valid=1 → out_valid=0, evt_count=0, FSM IDLE, source 0 granted first afterwards.
- cnt_clr coincident with a handshake when evt_count=7 → evt_count=0; and 2^CNT_W−1 plus one handshake → 0. With the macro, src_urgent[1] during a src0 burst → next pop is src1.

Source files
------------

// File: rtl/event_drain_arbiter.sv
// event_drain_arbiter: drains N_SRC peek-style event FIFOs into one registered
// valid/ready stream. Sources are scheduled round-robin with bounded bursts.
// Optional build macro EVENT_DRAIN_ARB_URGENT_EN adds a src_urgent input.
// Urgent sources with pending events preempt the round-robin schedule.
module event_drain_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned EVT_W     = 72,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned SRC_W    = $clog2(N_SRC),
  localparam int unsigned BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_SRC-1:0]       src_valid,
`ifdef EVENT_DRAIN_ARB_URGENT_EN
  input  logic [N_SRC-1:0]       src_urgent,
`endif
  input  logic [N_SRC*EVT_W-1:0] src_data,
  output logic [N_SRC-1:0]       src_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EVT_W-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   busy,
  output logic [CNT_W-1:0]       evt_count,
  input  logic                   cnt_clr
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] lock_q;
  logic [BC_W-1:0]  burst_cnt_q;
  logic             out_valid_q;
  logic [EVT_W-1:0] out_data_q;
  logic [SRC_W-1:0] out_src_q;
  logic [CNT_W-1:0] evt_count_q;

  logic [N_SRC-1:0] elig;
  logic [SRC_W-1:0] scan_base;
  logic [SRC_W-1:0] cand_idx;
  logic             cand_found;
  logic             lock_keep;
  logic             preempt;
  logic             load_ok;
  logic             pop_fire;
  logic             handshake;
  logic [N_SRC-1:0] pop_vec;
  int unsigned      idx;

  assign load_ok   = !out_valid_q || out_ready;
  assign handshake = out_valid_q && out_ready;
  assign pop_fire  = en && load_ok && cand_found;

  // Candidate selection: continue the locked burst, otherwise round-robin scan.
  always_comb begin
    elig       = src_valid;
    preempt    = 1'b0;
    cand_found = 1'b0;
    cand_idx   = '0;
    lock_keep  = 1'b0;
    idx        = 0;
`ifdef EVENT_DRAIN_ARB_URGENT_EN
    if (|(src_urgent & src_valid)) begin
      elig    = src_urgent & src_valid;
      preempt = !elig[lock_q];
    end
`endif
    // A release scans from the locked source, which becomes the new rr_ptr.
    scan_base = (state_q == StBurst) ? lock_q : rr_ptr_q;
    if (state_q == StBurst && src_valid[lock_q] && !preempt &&
        burst_cnt_q < BC_W'(MAX_BURST)) begin
      cand_found = 1'b1;
      cand_idx   = lock_q;
      lock_keep  = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= N_SRC; k++) begin
        idx = (32'(scan_base) + k) % N_SRC;
        if (!cand_found && elig[idx]) begin
          cand_found = 1'b1;
          cand_idx   = SRC_W'(idx);
        end
      end
    end
  end

  // One-hot pop, held low while reset is asserted.
  always_comb begin
    pop_vec = '0;
    if (pop_fire) pop_vec = N_SRC'(1) << cand_idx;
    src_pop = rst_n ? pop_vec : '0;
  end

  // Output register, event counter and scheduling FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= SRC_W'(N_SRC - 1);
      lock_q      <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      evt_count_q <= '0;
    end else begin
      if (pop_fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= src_data[32'(cand_idx)*EVT_W +: EVT_W];
        out_src_q   <= cand_idx;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (cnt_clr) begin
        evt_count_q <= '0;
      end else if (handshake) begin
        evt_count_q <= evt_count_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (pop_fire) begin
            if (MAX_BURST == 1) begin
              rr_ptr_q <= cand_idx;
            end else begin
              lock_q      <= cand_idx;
              burst_cnt_q <= BC_W'(1);
              state_q     <= StBurst;
            end
          end
        end
        StBurst: begin
          // A stall (en low or output full) holds lock and burst count.
          if (en && load_ok) begin
            if (lock_keep) begin
              if (burst_cnt_q == BC_W'(MAX_BURST - 1)) begin
                rr_ptr_q    <= lock_q;
                burst_cnt_q <= '0;
                state_q     <= StIdle;
              end else begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
              end
            end else if (pop_fire) begin
              // Release and re-lock in the same cycle, no idle bubble.
              rr_ptr_q    <= lock_q;
              lock_q      <= cand_idx;
              burst_cnt_q <= BC_W'(1);
            end else begin
              rr_ptr_q    <= lock_q;
              burst_cnt_q <= '0;
              state_q     <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign evt_count = evt_count_q;
  assign busy      = out_valid_q || (|src_valid);

endmodule

// File: tb/tb_event_drain_arbiter.sv
// Directed self-checking bench for event_drain_arbiter (default build).
// Sources are modelled as FIFOs with a pop counter and an event budget.
module tb_event_drain_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned EW    = 72;
  localparam int unsigned CW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    src_valid;
  logic [N*EW-1:0] src_data;
  logic [N-1:0]    src_pop;
  logic            out_valid;
  logic            out_ready;
  logic [EW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            busy;
  logic [CW-1:0]   evt_count;
  logic            cnt_clr;

  int pop_cnt[N] = '{default: 0};
  int avail[N]   = '{default: 0};
  int bad_pop    = 0;
  int checks     = 0;
  int failures   = 0;
  int p0;

  event_drain_arbiter #(
    .N_SRC(N), .EVT_W(EW), .MAX_BURST(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .src_valid(src_valid), .src_data(src_data),
    .src_pop(src_pop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .busy(busy), .evt_count(evt_count), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ev(input int i, input int n);
    return {8'(i), 32'hC0DE_0000, 32'(n)};
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_valid[i]          = pop_cnt[i] < avail[i];
      src_data[i*EW +: EW]  = ev(i, pop_cnt[i]);
    end
  end

  // FIFO model: a pop consumes the head event; popping an empty source is illegal.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (src_pop[i]) begin
        if (!src_valid[i]) bad_pop <= bad_pop + 1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < N; i++) avail[i] = pop_cnt[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_evt_count", EW'(evt_count), EW'(0));
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b0; cnt_clr = 1'b0;
    avail[0] = 3;
    #3;
    chk("init_out_valid", EW'(out_valid), EW'(0));
    chk("init_out_data", out_data, EW'(0));
    chk("init_out_src", EW'(out_src), EW'(0));
    chk("init_evt_count", EW'(evt_count), EW'(0));
    chk("init_pop_gated", EW'(src_pop), EW'(0));
    chk("init_busy", EW'(busy), EW'(1));
    avail[0] = 0;
    tick();

    // Round-robin between sources 0 and 2 with bursts of four.
    out_ready = 1'b1;
    avail[0] = pop_cnt[0] + 100;
    avail[2] = pop_cnt[2] + 100;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("rr_pop_%0d", c), EW'(src_pop), EW'(((c / 4) % 2) ? 4'b0100 : 4'b0001));
      if (c > 0)
        chk($sformatf("rr_src_%0d", c), EW'(out_src), EW'((((c - 1) / 4) % 2) ? 2 : 0));
      if (c == 9) chk("rr_evt_count_8", EW'(evt_count), EW'(8));
      tick();
    end
    drain_all();
    do_reset();

    // Single source with six events crosses a burst boundary without a bubble.
    p0 = pop_cnt[3];
    avail[3] = p0 + 6;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("solo_pop_%0d", c), EW'(src_pop), EW'((c < 6) ? 4'b1000 : 4'b0000));
      if (c >= 1 && c <= 6) begin
        chk($sformatf("solo_valid_%0d", c), EW'(out_valid), EW'(1));
        chk($sformatf("solo_data_%0d", c), out_data, ev(3, p0 + c - 1));
      end
      if (c == 7) begin
        chk("solo_valid_end", EW'(out_valid), EW'(0));
        chk("solo_evt_count", EW'(evt_count), EW'(6));
        chk("solo_busy_end", EW'(busy), EW'(0));
      end
      tick();
    end
    do_reset();

    // Backpressure: output held stable and no pops while out_ready is low.
    p0 = pop_cnt[1];
    avail[1] = p0 + 20;
    #1;
    chk("stall_pop_s0", EW'(src_pop), EW'(4'b0010));
    tick();
    chk("stall_data_s1", out_data, ev(1, p0));
    tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_data_%0d", c), out_data, ev(1, p0 + 1));
      chk($sformatf("stall_src_%0d", c), EW'(out_src), EW'(1));
      chk($sformatf("stall_pop_%0d", c), EW'(src_pop), EW'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_resume_pop", EW'(src_pop), EW'(4'b0010));
    tick();
    chk("stall_resume_d2", out_data, ev(1, p0 + 2));
    tick();
    chk("stall_resume_d3", out_data, ev(1, p0 + 3));
    chk("stall_evt_count", EW'(evt_count), EW'(3));
    drain_all();
    do_reset();

    // en low blocks pops; the held output still drains; lock resumes after.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) avail[i] = pop_cnt[i] + 50;
    #1;
    chk("en_first_pop", EW'(src_pop), EW'(4'b0001));
    tick();
    en = 1'b0;
    #1;
    chk("en_off_pop_a", EW'(src_pop), EW'(0));
    out_ready = 1'b1;
    #1;
    chk("en_off_pop_b", EW'(src_pop), EW'(0));
    tick();
    chk("en_off_drained", EW'(out_valid), EW'(0));
    chk("en_off_pop_c", EW'(src_pop), EW'(0));
    tick();
    chk("en_off_evt", EW'(evt_count), EW'(1));
    en = 1'b1;
    #1;
    chk("en_resume_pop", EW'(src_pop), EW'(4'b0001));
    drain_all();
    do_reset();

    // Reset mid-burst on source 2 discards the held event; source 0 wins after.
    avail[2] = pop_cnt[2] + 10;
    #1;
    chk("mid_pop_a", EW'(src_pop), EW'(4'b0100));
    tick();
    avail[0] = pop_cnt[0] + 10;
    #1;
    chk("mid_lock_held", EW'(src_pop), EW'(4'b0100));
    chk("mid_out_valid", EW'(out_valid), EW'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", EW'(out_valid), EW'(0));
    chk("mid_rst_evt", EW'(evt_count), EW'(0));
    chk("mid_rst_pop", EW'(src_pop), EW'(0));
    rst_n = 1'b1;
    #1;
    chk("mid_after_pop", EW'(src_pop), EW'(4'b0001));
    drain_all();
    tick();
    do_reset();

    // Counter clear beats a coincident handshake; counter wraps at 2^CW.
    avail[0] = pop_cnt[0] + 40;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (evt_count == 7) break;
      tick();
    end
    chk("clr_reach_7", EW'(evt_count), EW'(7));
    chk("clr_hs_pending", EW'(out_valid), EW'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_result", EW'(evt_count), EW'(0));
    for (int c = 0; c < 30; c++) begin
      if (evt_count == 15) break;
      tick();
    end
    chk("wrap_reach_max", EW'(evt_count), EW'(15));
    tick();
    chk("wrap_result", EW'(evt_count), EW'(0));
    drain_all();
    tick();

    chk("no_empty_pops", EW'(bad_pop), EW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
